// File: rtl/swan64_stream_ctrl.sv
// rtl/swan64_stream_ctrl.sv - stream initiator for one SWAN64K256 encrypt/decrypt core
// Optional watchdog: define SWAN_CTRL_TIMEOUT_EN to add the WAIT counter and timeout_err.
module swan64_stream_ctrl #(
  parameter int BLOCK_SIZE     = 64,
  parameter int KEY_SIZE       = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:KEY_SIZE-1]   key_in,
  input  logic                  key_load,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:BLOCK_SIZE-1] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:BLOCK_SIZE-1] out_data,
  output logic                  core_start,
  output logic [0:BLOCK_SIZE-1] core_inp,
  output logic [0:KEY_SIZE-1]   core_key,
  input  logic                  core_ready,
  input  logic [0:BLOCK_SIZE-1] core_out,
  output logic                  busy
`ifdef SWAN_CTRL_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_STALL = 2'd3
  } state_t;

  state_t r_state;

  logic w_out_free;
  assign w_out_free = !out_valid || out_ready;

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

`ifdef SWAN_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_wait_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      core_start <= 1'b0;
      core_inp   <= '0;
      core_key   <= '0;
`ifdef SWAN_CTRL_TIMEOUT_EN
      r_wait_cnt  <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      // A drain this cycle frees the register; a capture below overrides it.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (key_load) core_key <= key_in;
          if (in_valid) begin
            core_inp   <= in_data;
            core_start <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
`ifdef SWAN_CTRL_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_ready) begin
            if (w_out_free) begin
              out_data  <= core_out;
              out_valid <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_STALL;
            end
          end
`ifdef SWAN_CTRL_TIMEOUT_EN
          else if (r_wait_cnt == C_LAST) begin
            timeout_err <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        S_STALL: begin
          // core_out is held by the core until the next start, so it is safe to take it late.
          if (out_ready) begin
            out_data  <= core_out;
            out_valid <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swan64_stream_ctrl.sv
// tb/tb_swan64_stream_ctrl.sv - directed bench for swan64_stream_ctrl with a stub cipher core
module tb_swan64_stream_ctrl;

  localparam logic [0:255] K_F  = {256{1'b1}};
  localparam logic [0:255] K_0  = '0;
  localparam logic [0:255] K_1  = {64{4'h1}};
  localparam logic [0:63]  ENC_MASK = 64'ha5a5a5a5a5a5a5a5;
  localparam logic [0:63]  DEC_MASK = 64'h5a5a5a5a5a5a5a5a;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [0:255] key_in = '0;
  logic         key_load = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:63]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [0:63]  out_data;
  logic         core_start;
  logic [0:63]  core_inp;
  logic [0:255] core_key;
  logic         core_ready = 1'b0;
  logic [0:63]  core_out = '0;
  logic         busy;
`ifdef SWAN_CTRL_TIMEOUT_EN
  logic         timeout_err;
`endif

  always #5 clk = ~clk;

  swan64_stream_ctrl #(
    .BLOCK_SIZE(64), .KEY_SIZE(256), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_inp(core_inp), .core_key(core_key),
    .core_ready(core_ready), .core_out(core_out), .busy(busy)
`ifdef SWAN_CTRL_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [0:63] act, input logic [0:63] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Stub core: known-answer vectors, otherwise a simple keyed mask.
  logic stub_dec = 1'b0;
  logic stub_dead = 1'b0;
  int   stub_lat = 3;
  int   stub_cnt = 0;
  logic stub_busy = 1'b0;

  function automatic logic [0:63] stub_f(input logic dec, input logic [0:255] k, input logic [0:63] d);
    logic [0:63] k0;
    k0 = k[0:63];
    if (!dec) begin
      if (k == K_F && d == 64'hf0debc9a78563412) return 64'hb57ffcf7a5449b9a;
      if (k == K_0 && d == 64'h8877665544332211) return 64'h3249d350bc89337c;
      if (k == K_1 && d == 64'hefcdab9078563412) return 64'h15cebc3b6e457d2b;
      return d ^ k0 ^ ENC_MASK;
    end
    if (k == K_F && d == 64'hb57ffcf7a5449b9a) return 64'hf0debc9a78563412;
    return d ^ k0 ^ DEC_MASK;
  endfunction

  always @(posedge clk) begin
    if (core_start) begin
      stub_cnt   <= stub_lat;
      stub_busy  <= 1'b1;
      core_ready <= 1'b0;
    end else if (stub_busy && !stub_dead) begin
      if (stub_cnt <= 1) begin
        core_ready <= 1'b1;
        core_out   <= stub_f(stub_dec, core_key, core_inp);
        stub_busy  <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end else begin
      core_ready <= 1'b0;
    end
  end

  int          cyc = 0;
  int          hs_cyc = 0;
  int          rise_cyc = 0;
  int          cs_cnt = 0;
  logic        prev_ov = 1'b0;
  logic [0:63] outq[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      if (in_valid && in_ready) hs_cyc = cyc;
      if (out_valid && !prev_ov) rise_cyc = cyc;
      if (out_valid && out_ready) outq.push_back(out_data);
      if (core_start) cs_cnt++;
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [0:255] k, input logic ld, input logic [0:63] d);
    for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
    chk_int("send_in_ready", int'(in_ready), 1);
    key_in   = k;
    key_load = ld;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    key_load = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 300 && outq.size() < n; i++) @(negedge clk);
    chk_int("wait_out_count", outq.size(), n);
  endtask

  typedef struct {
    logic [0:255] key;
    logic [0:63]  din;
    logic [0:63]  dout;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n0;
    int cs0;
    int h1;
    logic [0:63] exp2;

    tbl[0] = '{K_F, 64'hf0debc9a78563412, 64'hb57ffcf7a5449b9a};
    tbl[1] = '{K_0, 64'h8877665544332211, 64'h3249d350bc89337c};
    tbl[2] = '{K_1, 64'hefcdab9078563412, 64'h15cebc3b6e457d2b};
    tbl[3] = '{K_0, 64'h0123456789abcdef, 64'ha486e0c22c0e684a};
    tbl[4] = '{K_1, 64'h0000000000000000, 64'hb4b4b4b4b4b4b4b4};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_core_inp", core_inp, 64'd0);
    chk("rst_core_key", core_key[0:63], 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // Encrypt table, key loaded in the same cycle as the block.
    stub_dec = 1'b0;
    stub_lat = 3;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n0  = outq.size();
      cs0 = cs_cnt;
      send(tbl[i].key, 1'b1, tbl[i].din);
      wait_out(n0 + 1);
      if (outq.size() > n0) chk($sformatf("tbl%0d_data", i), outq[n0], tbl[i].dout);
      chk_int($sformatf("tbl%0d_latency", i), rise_cyc - hs_cyc, stub_lat + 3);
      chk_int($sformatf("tbl%0d_start_pulses", i), cs_cnt - cs0, 1);
    end

    // Back-to-back blocks with out_ready held high.
    @(negedge clk);
    n0 = outq.size();
    send(K_0, 1'b1, 64'h8877665544332211);
    h1 = hs_cyc;
    send(K_1, 1'b1, 64'hefcdab9078563412);
    chk_int("b2b_throughput", hs_cyc - h1, stub_lat + 3);
    wait_out(n0 + 2);
    if (outq.size() >= n0 + 2) begin
      chk("b2b_first", outq[n0], 64'h3249d350bc89337c);
      chk("b2b_second", outq[n0 + 1], 64'h15cebc3b6e457d2b);
    end

    // Decrypt with the output held: second result must stall behind the first.
    stub_dec  = 1'b1;
    out_ready = 1'b0;
    n0 = outq.size();
    send(K_F, 1'b1, 64'hb57ffcf7a5449b9a);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    chk("stall_first_held", out_data, 64'hf0debc9a78563412);
    exp2 = 64'h0011223344556677 ^ 64'hffffffffffffffff ^ DEC_MASK;
    send(K_F, 1'b0, 64'h0011223344556677);
    repeat (stub_lat + 6) @(negedge clk);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_out_data", out_data, 64'hf0debc9a78563412);
    chk_int("stall_no_drain", outq.size(), n0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_second_valid", 64'(out_valid), 64'd1);
    chk("stall_second_data", out_data, exp2);
    chk("stall_exit_idle", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    chk_int("stall_total", outq.size(), n0 + 2);
    if (outq.size() >= n0 + 2) begin
      chk("stall_q0", outq[n0], 64'hf0debc9a78563412);
      chk("stall_q1", outq[n0 + 1], exp2);
    end

    // key_load during WAIT must be ignored.
    stub_dec = 1'b0;
    stub_lat = 6;
    n0 = outq.size();
    send(K_F, 1'b1, 64'hf0debc9a78563412);
    @(negedge clk);
    key_in   = K_0;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    wait_out(n0 + 1);
    if (outq.size() > n0) chk("keyign_result", outq[n0], 64'hb57ffcf7a5449b9a);
    chk("keyign_core_key", core_key[192:255], 64'hffffffffffffffff);
    send(K_0, 1'b0, 64'h8877665544332211);
    wait_out(n0 + 2);
    if (outq.size() > n0 + 1) chk("keyign_next_block", outq[n0 + 1], 64'hd22d3c0f1e69784b);

    // Reset while waiting on the core; the late result must vanish.
    stub_lat = 10;
    @(negedge clk);
    n0 = outq.size();
    send(K_F, 1'b1, 64'hf0debc9a78563412);
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_core_inp", core_inp, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk_int("midrst_no_output", outq.size(), n0);
    chk("midrst_out_valid_late", 64'(out_valid), 64'd0);

`ifdef SWAN_CTRL_TIMEOUT_EN
    stub_dead = 1'b1;
    n0 = outq.size();
    send(K_F, 1'b1, 64'h1);
    repeat (16) @(negedge clk);
    chk("to_not_yet", 64'(timeout_err), 64'd0);
    chk("to_busy_wait", 64'(busy), 64'd1);
    @(negedge clk);
    chk("to_flag", 64'(timeout_err), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_out_valid", 64'(out_valid), 64'd0);
    repeat (10) @(negedge clk);
    chk("to_sticky", 64'(timeout_err), 64'd1);
    chk_int("to_no_output", outq.size(), n0);
    rst = 1'b0;
    #1;
    chk("to_cleared", 64'(timeout_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1);
  end

endmodule
